// File: rtl/gemm_ctrl_pkg.sv
// gemm_ctrl_pkg
// Shared types for the GEMM tile controller:
//   state_e      - controller FSM states (2-bit encoding)
//   loop_order_e - loop nesting selection; K is always the innermost loop
package gemm_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_BUSY   = 2'd1,
      ST_FLUSH  = 2'd2,
      ST_FINISH = 2'd3
   } state_e;

   typedef enum logic {
      ORDER_M_OUTER = 1'b0,   // M outer, N middle
      ORDER_N_OUTER = 1'b1    // N outer, M middle
   } loop_order_e;

endpackage

// File: rtl/wrap_counter.sv
// wrap_counter
// Index counter that wraps to zero after reaching a runtime ceiling.
// Ports:
//   clk_i, rst_ni  - clock, asynchronous active-low reset
//   tick_i         - advance the count by one (wraps at the ceiling)
//   clear_i        - force the count to zero (has priority over tick_i)
//   ceiling_i      - highest count value (size - 1)
//   count_o        - current count
//   last_o         - count is at (or, defensively, beyond) the ceiling
module wrap_counter #(
   parameter int Width = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             tick_i,
   input  logic             clear_i,
   input  logic [Width-1:0] ceiling_i,
   output logic [Width-1:0] count_o,
   output logic             last_o
);

   logic [Width-1:0] count_q;
   logic [Width-1:0] count_d;

   // Using >= keeps the counter bounded even if the ceiling ever shrinks below it.
   assign last_o  = (count_q >= ceiling_i);
   assign count_o = count_q;

   // Next-count selection: clear, wrap or increment.
   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (tick_i) begin
         if (last_o) begin
            count_d = '0;
         end else begin
            count_d = count_q + Width'(1);
         end
      end else begin
         count_d = count_q;
      end
   end

   // Count register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/gemm_tile_controller.sv
// gemm_tile_controller
// Sequences operand beats over an M x N x K GEMM iteration space (K innermost,
// M/N nesting selectable) and emits one tagged result per output element.
// Ports:
//   clk_i, rst_ni                    - clock, asynchronous active-low reset
//   start_i, loop_order_i            - start request and loop nesting (sampled in Idle)
//   M_size_i, K_size_i, N_size_i     - problem dimensions in beats
//   input_valid_i / input_ready_o    - operand beat handshake
//   M_count_o, N_count_o, K_count_o  - indices of the current beat
//   acc_clear_o                      - current beat starts a new output element
//   result_valid_o / result_ready_i  - result handshake
//   result_m_o, result_n_o           - result tag (M/N indices of the element)
//   busy_o                           - operation in progress (Busy or Flush)
//   done_o                           - single-cycle completion pulse
module gemm_tile_controller
   import gemm_ctrl_pkg::*;
#(
   parameter int AddrWidth = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 start_i,
   input  logic                 loop_order_i,
   input  logic [AddrWidth-1:0] M_size_i,
   input  logic [AddrWidth-1:0] K_size_i,
   input  logic [AddrWidth-1:0] N_size_i,
   input  logic                 input_valid_i,
   output logic                 input_ready_o,
   output logic [AddrWidth-1:0] M_count_o,
   output logic [AddrWidth-1:0] N_count_o,
   output logic [AddrWidth-1:0] K_count_o,
   output logic                 acc_clear_o,
   output logic                 result_valid_o,
   input  logic                 result_ready_i,
   output logic [AddrWidth-1:0] result_m_o,
   output logic [AddrWidth-1:0] result_n_o,
   output logic                 busy_o,
   output logic                 done_o
);

   state_e                 state_q;
   loop_order_e            order_q;
   logic [AddrWidth-1:0]   m_size_q;
   logic [AddrWidth-1:0]   n_size_q;
   logic [AddrWidth-1:0]   k_size_q;
   logic                   result_valid_q;
   logic [AddrWidth-1:0]   result_m_q;
   logic [AddrWidth-1:0]   result_n_q;
   logic                   busy_q;
   logic                   done_q;

   logic [AddrWidth-1:0]   m_count_s;
   logic [AddrWidth-1:0]   n_count_s;
   logic [AddrWidth-1:0]   k_count_s;
   logic                   m_last_s;
   logic                   n_last_s;
   logic                   k_last_s;
   logic                   m_tick_s;
   logic                   n_tick_s;
   logic                   mid_tick_s;
   logic                   outer_tick_s;
   logic                   mid_last_s;
   logic                   outer_last_s;
   logic                   beat_s;
   logic                   last_beat_s;
   logic                   clear_s;
   logic                   start_zero_s;

   // Ready only while Busy and the result slot is free or being drained this cycle.
   assign input_ready_o = (state_q == ST_BUSY) && (!result_valid_q || result_ready_i);
   assign beat_s        = input_valid_i && input_ready_o;

   // Middle/outer roles are assigned by the latched loop order.
   assign mid_last_s    = (order_q == ORDER_M_OUTER) ? n_last_s : m_last_s;
   assign outer_last_s  = (order_q == ORDER_M_OUTER) ? m_last_s : n_last_s;
   assign mid_tick_s    = beat_s && k_last_s;
   assign outer_tick_s  = mid_tick_s && mid_last_s;
   assign n_tick_s      = (order_q == ORDER_M_OUTER) ? mid_tick_s : outer_tick_s;
   assign m_tick_s      = (order_q == ORDER_M_OUTER) ? outer_tick_s : mid_tick_s;
   assign last_beat_s   = beat_s && k_last_s && mid_last_s && outer_last_s;

   assign clear_s       = ((state_q == ST_IDLE) && start_i) || (state_q == ST_FINISH);
   assign start_zero_s  = (M_size_i == '0) || (N_size_i == '0) || (K_size_i == '0);

   wrap_counter #(.Width(AddrWidth)) u_k_counter (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .tick_i    (beat_s),
      .clear_i   (clear_s),
      .ceiling_i (k_size_q - AddrWidth'(1)),
      .count_o   (k_count_s),
      .last_o    (k_last_s)
   );

   wrap_counter #(.Width(AddrWidth)) u_n_counter (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .tick_i    (n_tick_s),
      .clear_i   (clear_s),
      .ceiling_i (n_size_q - AddrWidth'(1)),
      .count_o   (n_count_s),
      .last_o    (n_last_s)
   );

   wrap_counter #(.Width(AddrWidth)) u_m_counter (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .tick_i    (m_tick_s),
      .clear_i   (clear_s),
      .ceiling_i (m_size_q - AddrWidth'(1)),
      .count_o   (m_count_s),
      .last_o    (m_last_s)
   );

   // Controller FSM with latched configuration, result register and status outputs.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q        <= ST_IDLE;
         order_q        <= ORDER_M_OUTER;
         m_size_q       <= '0;
         n_size_q       <= '0;
         k_size_q       <= '0;
         result_valid_q <= 1'b0;
         result_m_q     <= '0;
         result_n_q     <= '0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
      end else begin
         // A new result wins over draining so continuous ready sees no bubble.
         if (beat_s && k_last_s) begin
            result_valid_q <= 1'b1;
            result_m_q     <= m_count_s;
            result_n_q     <= n_count_s;
         end else if (result_ready_i) begin
            result_valid_q <= 1'b0;
         end else begin
            result_valid_q <= result_valid_q;
         end

         case (state_q)
            ST_IDLE: begin
               if (start_i) begin
                  order_q  <= loop_order_e'(loop_order_i);
                  m_size_q <= M_size_i;
                  n_size_q <= N_size_i;
                  k_size_q <= K_size_i;
                  if (start_zero_s) begin
                     state_q <= ST_FINISH;
                     done_q  <= 1'b1;
                     busy_q  <= 1'b0;
                  end else begin
                     state_q <= ST_BUSY;
                     done_q  <= 1'b0;
                     busy_q  <= 1'b1;
                  end
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_BUSY: begin
               if (last_beat_s) begin
                  state_q <= ST_FLUSH;
               end else begin
                  state_q <= ST_BUSY;
               end
            end
            ST_FLUSH: begin
               if (result_valid_q && result_ready_i) begin
                  state_q <= ST_FINISH;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
               end else begin
                  state_q <= ST_FLUSH;
               end
            end
            ST_FINISH: begin
               state_q <= ST_IDLE;
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= ST_IDLE;
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign M_count_o      = m_count_s;
   assign N_count_o      = n_count_s;
   assign K_count_o      = k_count_s;
   assign acc_clear_o    = (state_q == ST_BUSY) && (k_count_s == '0);
   assign result_valid_o = result_valid_q;
   assign result_m_o     = result_m_q;
   assign result_n_o     = result_n_q;
   assign busy_o         = busy_q;
   assign done_o         = done_q;

endmodule

// File: tb/tb_gemm_tile_controller.sv
// tb_gemm_tile_controller
// Table of GEMM runs, each driven through run_case. A reference loop nest
// predicts every beat's indices and pushes the expected result tags into a
// scoreboard queue, which is popped whenever the DUT hands over a result.
module tb_gemm_tile_controller;

   localparam int AW = 16;

   logic          clk_i = 1'b0;
   logic          rst_ni;
   logic          start_i;
   logic          loop_order_i;
   logic [AW-1:0] M_size_i;
   logic [AW-1:0] K_size_i;
   logic [AW-1:0] N_size_i;
   logic          input_valid_i;
   logic          input_ready_o;
   logic [AW-1:0] M_count_o;
   logic [AW-1:0] N_count_o;
   logic [AW-1:0] K_count_o;
   logic          acc_clear_o;
   logic          result_valid_o;
   logic          result_ready_i;
   logic [AW-1:0] result_m_o;
   logic [AW-1:0] result_n_o;
   logic          busy_o;
   logic          done_o;

   gemm_tile_controller #(.AddrWidth(AW)) dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .start_i        (start_i),
      .loop_order_i   (loop_order_i),
      .M_size_i       (M_size_i),
      .K_size_i       (K_size_i),
      .N_size_i       (N_size_i),
      .input_valid_i  (input_valid_i),
      .input_ready_o  (input_ready_o),
      .M_count_o      (M_count_o),
      .N_count_o      (N_count_o),
      .K_count_o      (K_count_o),
      .acc_clear_o    (acc_clear_o),
      .result_valid_o (result_valid_o),
      .result_ready_i (result_ready_i),
      .result_m_o     (result_m_o),
      .result_n_o     (result_n_o),
      .busy_o         (busy_o),
      .done_o         (done_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      int m;
      int n;
      int k;
      bit order;
      bit gappy;     // drop input_valid_i every third cycle
      int stall;     // cycles of result_ready_i low after the first result
      int poke;      // cycle at which a stray start_i is pulsed (-1 = none)
      int rst_beat;  // assert reset after this many beats (0 = none)
   } case_t;

   typedef struct packed {
      logic [AW-1:0] m;
      logic [AW-1:0] n;
   } tag_t;

   tag_t  sb_q[$];
   case_t cases[9];
   int    checks = 0;
   int    errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_input_ready"}, 64'(input_ready_o), 64'd0);
      chk({tag, "_acc_clear"}, 64'(acc_clear_o), 64'd0);
      chk({tag, "_busy"}, 64'(busy_o), 64'd0);
      chk({tag, "_done"}, 64'(done_o), 64'd0);
      chk({tag, "_result_valid"}, 64'(result_valid_o), 64'd0);
      chk({tag, "_counts"}, 64'({M_count_o, N_count_o, K_count_o}), 64'd0);
      chk({tag, "_tags"}, 64'({result_m_o, result_n_o}), 64'd0);
   endtask

   task automatic run_case(input case_t c);
      int  mm, nn, kk, beats, pops, hold, cyc, last_pop, done_cyc;
      bit  first_res, beat, zero, aborted;
      mm = 0; nn = 0; kk = 0; beats = 0; pops = 0; hold = 0; cyc = 0;
      last_pop = -1; done_cyc = -1; first_res = 1'b0; aborted = 1'b0;
      zero = (c.m == 0) || (c.n == 0) || (c.k == 0);
      sb_q.delete();

      @(negedge clk_i);
      M_size_i       = 16'(c.m);
      N_size_i       = 16'(c.n);
      K_size_i       = 16'(c.k);
      loop_order_i   = c.order;
      input_valid_i  = 1'b0;
      result_ready_i = 1'b1;
      start_i        = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;

      while (done_cyc < 0 && cyc < 2000 && !aborted) begin
         result_ready_i = (hold == 0);
         if (hold > 0) hold--;
         input_valid_i = c.gappy ? (cyc % 3 != 2) : 1'b1;
         if (cyc == c.poke) begin
            start_i      = 1'b1;
            M_size_i     = 16'd5;
            N_size_i     = 16'd7;
            K_size_i     = 16'd1;
            loop_order_i = ~loop_order_i;
         end else begin
            start_i = 1'b0;
         end
         #1;
         beat = input_valid_i && input_ready_o;

         chk("busy", 64'(busy_o), 64'(!zero && !done_o));
         chk("m_count", 64'(M_count_o), 64'(mm));
         chk("n_count", 64'(N_count_o), 64'(nn));
         chk("k_count", 64'(K_count_o), 64'(kk));
         if (result_valid_o && !result_ready_i)
            chk("stall_input_ready", 64'(input_ready_o), 64'd0);

         if (result_valid_o) begin
            chk("result_expected", 64'(sb_q.size() != 0), 64'd1);
            if (sb_q.size() != 0) begin
               chk("result_m", 64'(result_m_o), 64'(sb_q[0].m));
               chk("result_n", 64'(result_n_o), 64'(sb_q[0].n));
               if (result_ready_i) begin
                  void'(sb_q.pop_front());
                  pops++;
                  last_pop = cyc;
               end
            end
         end

         if (beat) begin
            chk("acc_clear", 64'(acc_clear_o), 64'(kk == 0));
            if (kk == c.k - 1) begin
               sb_q.push_back('{m: 16'(mm), n: 16'(nn)});
               if (!first_res && c.stall > 0) begin
                  first_res = 1'b1;
                  hold = c.stall;
               end
               kk = 0;
               if (c.order == 1'b0) begin
                  if (nn == c.n - 1) begin
                     nn = 0;
                     mm = (mm == c.m - 1) ? 0 : mm + 1;
                  end else begin
                     nn++;
                  end
               end else begin
                  if (mm == c.m - 1) begin
                     mm = 0;
                     nn = (nn == c.n - 1) ? 0 : nn + 1;
                  end else begin
                     mm++;
                  end
               end
            end else begin
               kk++;
            end
            beats++;
         end

         if (done_o) done_cyc = cyc;
         if (c.rst_beat > 0 && beats == c.rst_beat) aborted = 1'b1;
         cyc++;
         @(negedge clk_i);
      end

      start_i       = 1'b0;
      input_valid_i = 1'b0;

      if (aborted) begin
         rst_ni = 1'b0;
         #1;
         chk_reset_outputs("midrun_reset");
         @(posedge clk_i);
         #1;
         chk_reset_outputs("midrun_reset_held");
         @(negedge clk_i);
         rst_ni = 1'b1;
         #1;
         chk("post_reset_busy", 64'(busy_o), 64'd0);
         chk("post_reset_done", 64'(done_o), 64'd0);
      end else begin
         chk("done_seen", 64'(done_cyc >= 0), 64'd1);
         chk("beat_total", 64'(beats), 64'(c.m * c.n * c.k));
         chk("result_total", 64'(pops), 64'(zero ? 0 : c.m * c.n));
         chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
         chk("done_latency", 64'(done_cyc), 64'(zero ? 0 : last_pop + 1));
         for (int i = 0; i < 3; i++) begin
            #1;
            chk("done_single_pulse", 64'(done_o), 64'd0);
            chk("idle_busy", 64'(busy_o), 64'd0);
            chk("idle_result_valid", 64'(result_valid_o), 64'd0);
            @(negedge clk_i);
         end
      end
   endtask

   initial begin
      case_t rerun;
      //          m  n  k  ord gap stall poke rst
      cases[0] = '{2, 2, 3, 1'b0, 1'b0, 0, -1, 0};
      cases[1] = '{2, 3, 1, 1'b1, 1'b0, 0, -1, 0};
      cases[2] = '{1, 2, 2, 1'b0, 1'b0, 5, -1, 0};
      cases[3] = '{2, 2, 0, 1'b0, 1'b0, 0, -1, 0};
      cases[4] = '{2, 2, 2, 1'b0, 1'b0, 0, -1, 5};
      cases[5] = '{3, 2, 2, 1'b0, 1'b0, 0,  3, 0};
      cases[6] = '{3, 2, 2, 1'b1, 1'b1, 2, -1, 0};
      cases[7] = '{1, 1, 1, 1'b1, 1'b0, 0, -1, 0};
      cases[8] = '{0, 3, 2, 1'b0, 1'b0, 0, -1, 0};

      rst_ni         = 1'b0;
      start_i        = 1'b0;
      loop_order_i   = 1'b0;
      M_size_i       = '0;
      N_size_i       = '0;
      K_size_i       = '0;
      input_valid_i  = 1'b0;
      result_ready_i = 1'b1;
      @(negedge clk_i);
      @(negedge clk_i);
      chk_reset_outputs("reset");
      rst_ni = 1'b1;

      for (int i = 0; i < 9; i++) begin
         run_case(cases[i]);
         if (cases[i].rst_beat > 0) begin
            rerun = cases[i];
            rerun.rst_beat = 0;
            run_case(rerun);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
